csr_access_ctrl: RTL
====================

# csr_access_ctrl

Sequences CSR instructions against the single-ported CSR file. Per request: read (when required), apply the RW/RS/RC modification, write back, and return the old value for rd. Sits between writeback (driven by `csr_params_t` from CSR decode) and the CSR file. Arbitrates the CSR file port between instruction accesses and direct writes from the trap unit; trap writes have priority.

## Interface
- `XLEN`, 32, CSR data width.
- `CSR_ADDR_WIDTH`, 12, CSR address width.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: CSR request present.
- `req_ready` out 1: request accepted this cycle.
- `req_params` in `csr_params_t`: read_enable, write_enable, input_select, write_func.
- `req_addr` in `CSR_ADDR_WIDTH`: CSR address.
- `req_rs1` in XLEN: rs1 register value.
- `req_uimm` in 5: immediate from the rs1 field.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out XLEN: old CSR value; 0 if read_enable=0.
- `resp_illegal` out 1: illegal-instruction indication.
- `trap_valid` in 1: trap-unit write request.
- `trap_ready` out 1: trap write performed this cycle.
- `trap_addr` in `CSR_ADDR_WIDTH`: trap write address.
- `trap_wdata` in XLEN: trap write data.
- `csr_en` out 1: CSR file port enable.
- `csr_we` out 1: CSR file write enable.
- `csr_addr` out `CSR_ADDR_WIDTH`: CSR file address.
- `csr_wdata` out XLEN: CSR file write data.
- `csr_rdata` in XLEN: combinational read data for `csr_addr`, valid when `csr_en`=1.
- `csr_exists` in 1: combinational; `csr_addr` is implemented, valid when `csr_en`=1.

## Operation
States: IDLE, READ, WRITE, RESP.

**IDLE**
- `trap_valid`=1: drive the port from the trap inputs (`csr_en`=`csr_we`=1); `trap_ready`=1, `req_ready`=0; stay in IDLE.
- Otherwise `req_ready`=1. On `req_valid`, register params, address and operand.
  - operand = input_select immediate ? zero-extended `req_uimm` : `req_rs1`.

**Next state after accept**
- write_enable && `req_addr[11:10]`==2'b11 (read-only space): RESP, illegal=1, no port activity.
- Else if read_enable || write_func!=RW: READ.
- Else: WRITE.

**READ**
- Drives `csr_en`=1, `csr_we`=0, `csr_addr`=addr; captures `csr_rdata` into the old-value register.
- `csr_exists`=0: illegal=1, go to RESP.
- Else: go to WRITE if write_enable, otherwise RESP.

**WRITE**
- `csr_en`=1, `csr_we`=`csr_exists`.
- `csr_wdata`: RW = operand; RS = old | operand; RC = old & ~operand.
- `csr_exists`=0: illegal=1, write suppressed.
- Always goes to RESP.

**RESP**
- `resp_valid`=1; `resp_rdata`=old value if read_enable, else 0.
- Leaves to IDLE on `resp_ready`.

**Port arbitration and reset**
- `trap_ready` is 1 only in IDLE. A trap arriving during READ/WRITE/RESP waits; the in-flight instruction completes first.
- Reset: state=IDLE. All outputs 0, including `resp_rdata`, `resp_illegal` and the port signals.
- Reset mid-operation abandons the request; no write is issued in the reset cycle or after it.

## Timing
- Accept at edge N. Port outputs are combinational from state plus registers.
  - Full RS/RC: READ in cycle N+1, WRITE in N+2, `resp_valid` from N+3.
  - RW without read: WRITE in N+1, resp from N+2.
  - Read-only (write_enable=0): READ in N+1, resp from N+2.
  - Illegal-by-address: resp from N+1.
- `resp_*` stay stable while `resp_valid` && !`resp_ready`.
- Throughput: one instruction per 2–4 cycles plus stall. `req_ready` is combinational (IDLE && !`trap_valid`).
- Trap write completes in the same cycle as `trap_ready`.

## Structure
- `csr_pkg` gets:
  - enum `csr_ctrl_state_t`;
  - `CSR_ADDR_WIDTH`;
  - `CSR_RO_PREFIX` = 2'b11.
- Existing `csr_params_t`, `csr_write_func` and `csr_input_sel` are reused unchanged.
- Sub-module `csr_modify`: combinational (write_func, old, operand) -> new value.

## Test plan
- CSRRS: addr 0x300, old 0x0000_0008, rs1 0x0000_0080 -> READ then WRITE of 0x0000_0088; resp_rdata 0x8 at N+3; illegal 0.
- CSRRWI with rd=x0 (read_enable=0): uimm 5 -> READ skipped; WRITE 0x5 at N+1; resp_rdata 0 at N+2.
- CSRRC on 0xC00 (read-only space) with write_enable=1 -> no `csr_en` pulse; resp_illegal=1 at N+1.
- CSRRS on unimplemented 0x7FF (`csr_exists`=0) -> `csr_we` never 1; resp_illegal=1.
- `trap_valid` and `req_valid` together in IDLE -> trap written (`trap_ready`=1), `req_ready`=0; request accepted the next cycle. A trap during WRITE -> held until IDLE.
- `resp_ready` held low 3 cycles -> resp stable. Reset asserted in WRITE -> `csr_we`=0 afterwards; outputs 0; state IDLE.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR types: decode parameters, write functions and access-controller states.
package csr_pkg;

  localparam int CSR_ADDR_WIDTH = 12;
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_write_func;

  typedef enum logic {
    CSR_SEL_RS1 = 1'b0,
    CSR_SEL_IMM = 1'b1
  } csr_input_sel;

  typedef struct packed {
    logic          read_enable;
    logic          write_enable;
    csr_input_sel  input_select;
    csr_write_func write_func;
  } csr_params_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_ctrl_state_t;

endpackage

// File: rtl/csr_modify.sv
// Combinational CSR read-modify step: RW replaces, RS sets bits, RC clears bits.
module csr_modify import csr_pkg::*; #(
  parameter int XLEN = 32
) (
  input  csr_write_func   func,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = operand;
    case (func)
      CSR_RW:  new_val = operand;
      CSR_RS:  new_val = old_val | operand;
      CSR_RC:  new_val = old_val & ~operand;
      default: new_val = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences CSR instructions (read / modify / write-back) on the single CSR file
// port; direct trap-unit writes win the port whenever the controller is idle.
module csr_access_ctrl import csr_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  csr_params_t               req_params,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]           req_rs1,
  input  logic [4:0]                req_uimm,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [XLEN-1:0]           resp_rdata,
  output logic                      resp_illegal,
  input  logic                      trap_valid,
  output logic                      trap_ready,
  input  logic [CSR_ADDR_WIDTH-1:0] trap_addr,
  input  logic [XLEN-1:0]           trap_wdata,
  output logic                      csr_en,
  output logic                      csr_we,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [XLEN-1:0]           csr_wdata,
  input  logic [XLEN-1:0]           csr_rdata,
  input  logic                      csr_exists
);

  csr_ctrl_state_t           state_q, state_d;
  logic                      re_q, re_d;
  logic                      we_q, we_d;
  csr_write_func             func_q, func_d;
  logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           operand_q, operand_d;
  logic [XLEN-1:0]           old_q, old_d;
  logic                      illegal_q, illegal_d;
  logic [XLEN-1:0]           new_val;

  csr_modify #(.XLEN(XLEN)) u_modify (
    .func    (func_q),
    .old_val (old_q),
    .operand (operand_q),
    .new_val (new_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      func_q    <= CSR_RW;
      addr_q    <= '0;
      operand_q <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      re_q      <= re_d;
      we_q      <= we_d;
      func_q    <= func_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    re_d      = re_q;
    we_d      = we_q;
    func_d    = func_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    old_d     = old_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (!trap_valid && req_valid) begin
          re_d      = req_params.read_enable;
          we_d      = req_params.write_enable;
          func_d    = req_params.write_func;
          addr_d    = req_addr;
          operand_d = (req_params.input_select == CSR_SEL_IMM) ?
                      {{(XLEN-5){1'b0}}, req_uimm} : req_rs1;
          // Old value is cleared so skipped or faulting reads return zero.
          old_d     = '0;
          illegal_d = 1'b0;
          if (req_params.write_enable &&
              req_addr[CSR_ADDR_WIDTH-1 -: 2] == CSR_RO_PREFIX) begin
            illegal_d = 1'b1;
            state_d   = ST_RESP;
          end else if (req_params.read_enable || req_params.write_func != CSR_RW) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_READ: begin
        if (!csr_exists) begin
          illegal_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          old_d   = csr_rdata;
          state_d = we_q ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: begin
        if (!csr_exists) illegal_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing reaches the file.
  always_comb begin
    req_ready    = 1'b0;
    trap_ready   = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    csr_en       = 1'b0;
    csr_we       = 1'b0;
    csr_addr     = '0;
    csr_wdata    = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (trap_valid) begin
            trap_ready = 1'b1;
            csr_en     = 1'b1;
            csr_we     = 1'b1;
            csr_addr   = trap_addr;
            csr_wdata  = trap_wdata;
          end else begin
            req_ready = 1'b1;
          end
        end
        ST_READ: begin
          csr_en   = 1'b1;
          csr_addr = addr_q;
        end
        ST_WRITE: begin
          csr_en    = 1'b1;
          csr_we    = csr_exists;
          csr_addr  = addr_q;
          csr_wdata = new_val;
        end
        ST_RESP: begin
          resp_valid   = 1'b1;
          resp_rdata   = re_q ? old_q : '0;
          resp_illegal = illegal_q;
        end
        default: ;
      endcase
    end
  end

endmodule
